// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: state encoding, BCD digit type, digit moduli.
// Used by stopwatch_bcd_counter and bcd_digit; no logic of its own.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  localparam int unsigned DEC_MOD = 10;
  localparam int unsigned SEX_MOD = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } state_e;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// Mod-MOD BCD digit: increments on en, wraps to 0 and raises co combinationally on the last value.
// Registered digit, zero extra latency; sync clear (sclr) has priority over en.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MOD = DEC_MOD
) (
  input  logic CLOCK_50,
  input  logic Clr,
  input  logic sclr,
  input  logic en,
  output bcd_t q,
  output logic co
);

  localparam bcd_t LAST = bcd_t'(MOD - 1);

  assign co = en && (q == LAST);

  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      q <= '0;
    end else if (sclr) begin
      q <= '0;
    end else if (en) begin
      q <= co ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Run/pause/zero MM:SS stopwatch: key sync -> IDLE/RUN/PAUSE FSM -> prescaler -> four BCD digits.
// Keys act 3 edges after first sampled low; optional lap display freeze under `LAP_HOLD_EN.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic CLOCK_50,
  input  logic Clr,
  input  logic key_run_n,
  input  logic key_zero_n,
  input  logic key_lap_n,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic running,
  output logic tick,
  output logic rollover,
  output logic lap_active
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW   = presc_width(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

`ifdef LAP_HOLD_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif

  logic [NK-1:0] keys_n, s1, s2, s3, press;

`ifdef LAP_HOLD_EN
  assign keys_n = {key_lap_n, key_zero_n, key_run_n};
`else
  assign keys_n = {key_zero_n, key_run_n};
`endif

  // Two-flop synchronizer plus an edge flop; the press pulse is registered once more.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      s1    <= '1;
      s2    <= '1;
      s3    <= '1;
      press <= '0;
    end else begin
      s1    <= keys_n;
      s2    <= s1;
      s3    <= s2;
      press <= ~s2 & s3;
    end
  end

  logic run_p, zero_p, zero_clr;
  assign run_p  = press[0];
  assign zero_p = press[1];

  state_e state, state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (run_p) state_nxt = PAUSE;
      end
      default: begin
        if (zero_p)     state_nxt = IDLE;
        else if (run_p) state_nxt = RUN;
      end
    endcase
  end

  // Zero only acts outside RUN, so it can never collide with a prescaler wrap.
  assign zero_clr = zero_p && (state != RUN);

  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
    end
  end

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (state == RUN) && (presc == PMAX);

  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      presc <= '0;
    end else if (zero_clr || state == IDLE) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= wrap ? '0 : presc + 1'b1;
    end
  end

  bcd_t  so_q, st_q, mo_q, mt_q;
  logic  so_co, st_co, mo_co, mt_co;
  mmss_t live, disp;

  bcd_digit #(.MOD(DEC_MOD)) u_sec_ones (
    .CLOCK_50(CLOCK_50), .Clr(Clr), .sclr(zero_clr), .en(wrap),  .q(so_q), .co(so_co));
  bcd_digit #(.MOD(SEX_MOD)) u_sec_tens (
    .CLOCK_50(CLOCK_50), .Clr(Clr), .sclr(zero_clr), .en(so_co), .q(st_q), .co(st_co));
  bcd_digit #(.MOD(DEC_MOD)) u_min_ones (
    .CLOCK_50(CLOCK_50), .Clr(Clr), .sclr(zero_clr), .en(st_co), .q(mo_q), .co(mo_co));
  bcd_digit #(.MOD(SEX_MOD)) u_min_tens (
    .CLOCK_50(CLOCK_50), .Clr(Clr), .sclr(zero_clr), .en(mo_co), .q(mt_q), .co(mt_co));

  assign live = {mt_q, mo_q, st_q, so_q};

  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else begin
      tick     <= wrap;
      rollover <= mt_co;
    end
  end

`ifdef LAP_HOLD_EN
  logic  lap_q;
  mmss_t snap;

  // Snapshot captures the count shown just before the press edge.
  always_ff @(posedge CLOCK_50 or negedge Clr) begin
    if (!Clr) begin
      lap_q <= 1'b0;
      snap  <= '0;
    end else if (zero_p) begin
      lap_q <= 1'b0;
    end else if (press[2] && state != IDLE) begin
      lap_q <= !lap_q;
      if (!lap_q) snap <= live;
    end
  end

  assign disp       = lap_q ? snap : live;
  assign lap_active = lap_q;
`else
  assign disp       = live;
  // key_lap_n stays on the port list for pin compatibility only.
  assign lap_active = key_lap_n & 1'b0;
`endif

  assign {min_tens, min_ones, sec_tens, sec_ones} = disp;

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Run/pause/zero stopwatch counting MM:SS in four BCD digits from CLOCK_50 through an internal prescaler. Sits directly upstream of the board's seven-segment decoders. Each digit output drives one 0–9 decoder without further arithmetic. It replaces the ad-hoc compare-and-clear seconds logic with a single registered timebase and digit chain.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 1, count rate; prescaler divisor DIV = CLK_HZ/TICK_HZ, must be ≥2
- CLOCK_50  in  1  system clock, all logic on rising edge
- Clr  in  1  reset, asynchronous, active-low
- key_run_n  in  1  run/pause push-button, active-low, asynchronous to clock (board-debounced)
- key_zero_n  in  1  zero push-button, active-low
- key_lap_n  in  1  lap push-button, active-low (used only with LAP_HOLD_EN)
- sec_ones  out  4  BCD 0–9
- sec_tens  out  4  BCD 0–5
- min_ones  out  4  BCD 0–9
- min_tens  out  4  BCD 0–5
- running  out  1  high in RUN
- tick  out  1  one-cycle pulse per count increment
- rollover  out  1  one-cycle pulse on 59:59→00:00
- lap_active  out  1  display frozen (LAP_HOLD_EN only, else 0)

## Operation
- Each key: 2-FF synchronizer plus a third flop; press = falling edge (stage2 low, stage3 high), one-cycle pulse. All three flops reset to 1.
- States: IDLE (stopped, zeroed), RUN, PAUSE.
  - IDLE + run press → RUN. RUN + run press → PAUSE. PAUSE + run press → RUN.
  - PAUSE or IDLE + zero press → IDLE; digits and prescaler cleared. Zero press in RUN is ignored.
  - Run and zero pressed in the same cycle: in RUN, run wins (→PAUSE); in PAUSE/IDLE, zero wins (→IDLE).
- Prescaler:
  - Counts 0..DIV-1 only in RUN. At DIV-1 it wraps to 0 and tick asserts.
  - Holds its value in PAUSE, so the partial second is preserved. Cleared in IDLE.
- Digit chain on tick:
  - sec_ones increments; carry at 9→0 into sec_tens.
  - sec_tens carries at 5→0 into min_ones; min_ones carries at 9→0 into min_tens.
  - min_tens wraps 5→0 and asserts rollover. Counting continues after 59:59→00:00.
- Tick coincident with a run press in RUN: the increment is applied and the state becomes PAUSE; the prescaler wraps to 0.
- No digit ever holds a value outside its range. Digit registers are only written with the increment result or 0.

## Timing
- Reset values: all digits 0, running 0, tick 0, rollover 0, lap_active 0, state IDLE, prescaler 0.
- Clr assertion takes effect immediately (asynchronous), including mid-run and mid-tick. Deassertion is synchronous to the first following edge.
- Key latency: a key first sampled low at edge k produces a press pulse after edge k+2. State and running update at edge k+3.
- First tick after RUN entry from IDLE: DIV cycles after the edge that sets running.
- All outputs are registered. Digits change on the same edge that tick and rollover assert. tick and rollover are high for exactly one cycle.
- A key held low yields one press only; release generates nothing.

## Configuration
- LAP_HOLD_EN defined:
  - A lap press in RUN or PAUSE toggles lap_active.
  - While lap_active=1, the digit outputs show a snapshot taken at the press; the internal count continues.
  - A zero press or Clr clears lap_active.
- LAP_HOLD_EN undefined:
  - key_lap_n is ignored (port kept for pin compatibility) and lap_active is tied 0.
  - Digit outputs always reflect the live count. No snapshot registers are built.

## Structure
- Package stopwatch_pkg: state enum (IDLE/RUN/PAUSE), 4-bit BCD digit typedef, digit moduli constants (10, 6), prescaler width function clog2(DIV).
- Sub-module bcd_digit: mod-N BCD counter with async active-low clear, sync clear, enable/carry-in, carry-out. Instantiated four times (N=10,6,10,6).

## Test plan
- CLK_HZ=10, TICK_HZ=1 (DIV=10) for all tests.
- Clr low mid-RUN at 03:27 → all digits 0, running 0, tick 0 before the next edge. Stays IDLE after release.
- Run press, 600 ticks → digits min_tens=1, others 0. tick count = 600, rollover never asserts.
- Run press, 3600 ticks → 00:00. rollover pulses exactly once, same cycle as the 3600th tick. running stays 1.
- Pause test:
  - Stimulus: run press; after 5 ticks plus 4 cycles, run press; wait 100 cycles; run press.
  - Response: digits hold 00:05 during the pause. The next tick arrives 6 cycles after running returns to 1.
- Zero press in RUN at 00:03 → ignored, counting continues. Zero press in PAUSE → 00:00, IDLE. Run+zero in the same cycle from PAUSE → IDLE.
- LAP_HOLD_EN:
  - Lap press at 00:12 → outputs frozen at 00:12 for 8 ticks.
  - Second lap press → outputs show 00:20.
  - Undefined build: lap press has no effect.
